// File: rtl/tm1638_key_events.sv
// TM1638 key-scan post-processor: extracts 8 keys, debounces each across scans,
// and queues discrete press/release events in a small FIFO with valid/ready.
module tm1638_key_events #(
  parameter int IN_BYTES       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            scan_valid,
  input  logic [7:0]                      scan_data [IN_BYTES],
  output logic [7:0]                      key_state,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [2:0]                      evt_key,
  output logic                            evt_pressed,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            evt_overflow,
  input  logic                            overflow_clear
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [7:0]    w_raw;
  logic          w_unused;
  logic [7:0]    w_diff;
  logic [7:0]    w_toggle;
  logic [2:0]    w_sel_idx;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_push_mask;
  logic          w_ovf_set;
  logic [LW-1:0] w_level_nxt;
  logic [3:0]    w_head;

  logic [7:0]    r_key_state;
  logic [CW-1:0] r_cnt [8];
  logic [7:0]    r_pend;
  logic [7:0]    r_pol;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          r_valid;
  logic          r_ovf;

  // Only bit 0 and bit 4 of the first four bytes carry keys.
  always_comb begin
    w_raw    = '0;
    w_unused = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_raw[i]     = scan_data[i][0];
      w_raw[4 + i] = scan_data[i][4];
      w_unused     = w_unused ^ (^scan_data[i][3:1]) ^ (^scan_data[i][7:5]);
    end
  end

  always_comb begin
    w_diff   = w_raw ^ r_key_state;
    w_toggle = '0;
    for (int k = 0; k < 8; k++)
      w_toggle[k] = scan_valid & w_diff[k] & (r_cnt[k] == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_state <= '0;
      for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
    end else if (scan_valid) begin
      for (int k = 0; k < 8; k++) begin
        if (!w_diff[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_cnt[k]       <= '0;
          r_key_state[k] <= ~r_key_state[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  // Lowest pending index wins; descending scan lets the last hit stick.
  always_comb begin
    w_sel_idx = '0;
    for (int k = 7; k >= 0; k--)
      if (r_pend[k]) w_sel_idx = 3'(k);
  end

  assign w_push      = (|r_pend) && (r_level != LVL_FULL);
  assign w_pop       = r_valid && evt_ready;
  assign w_push_mask = w_push ? (8'b1 << w_sel_idx) : 8'b0;
  assign w_ovf_set   = |(w_toggle & r_pend & ~w_push_mask);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend  <= '0;
      r_pol   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend  <= (r_pend & ~w_push_mask) | w_toggle;
      r_pol   <= (r_pol & ~w_toggle) | (~r_key_state & w_toggle);
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      if (w_ovf_set)           r_ovf <= 1'b1;
      else if (overflow_clear) r_ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_sel_idx, r_pol[w_sel_idx]};
  end

  assign w_head       = r_mem[r_rd];
  assign key_state    = r_key_state;
  assign evt_valid    = r_valid;
  assign evt_key      = r_valid ? w_head[3:1] : 3'b0;
  assign evt_pressed  = r_valid ? w_head[0] : 1'b0;
  assign fifo_level   = r_level;
  assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_tm1638_key_events.sv
// Directed bench for tm1638_key_events (DEBOUNCE_SCANS=3, FIFO_DEPTH=8).
module tb_tm1638_key_events;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_valid;
  logic [7:0] scan_data [4];
  logic [7:0] key_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_pressed;
  logic [3:0] fifo_level;
  logic       evt_overflow;
  logic       overflow_clear;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected drain orders, each entry {key, pressed}.
  logic [3:0] exp_d4 [10] = '{4'h0, 4'h2, 4'h8, 4'hA, 4'hE, 4'h1, 4'h3, 4'h5, 4'h7, 4'h9};
  logic [3:0] exp_d5 [9]  = '{4'h0, 4'h2, 4'h6, 4'h8, 4'h1, 4'h3, 4'h7, 4'h9, 4'h5};

  tm1638_key_events #(.IN_BYTES(4), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_data(scan_data),
    .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_key(evt_key), .evt_pressed(evt_pressed), .fifo_level(fifo_level),
    .evt_overflow(evt_overflow), .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scan(input logic [7:0] b0, b1, b2, b3);
    scan_data[0] = b0; scan_data[1] = b1; scan_data[2] = b2; scan_data[3] = b3;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic scan3(input logic [7:0] b0, b1, b2, b3);
    for (int i = 0; i < 3; i++) scan(b0, b1, b2, b3);
  endtask

  initial begin
    reset_n = 1'b0; scan_valid = 1'b0; evt_ready = 1'b0; overflow_clear = 1'b0;
    for (int i = 0; i < 4; i++) scan_data[i] = 8'h00;
    idle(3);
    chk("rst_key_state", key_state, 8'h00);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", evt_overflow, 0);
    chk("rst_evt_key", evt_key, 0);
    chk("rst_evt_pressed", evt_pressed, 0);
    reset_n = 1'b1;
    idle(2);

    // Key 1 pressed after three scans, single event two cycles later.
    evt_ready = 1'b1;
    scan(8'h00, 8'h01, 8'h00, 8'h00);
    chk("t1_state_s1", key_state, 8'h00);
    tick();
    chk("t1_noevt_s1", evt_valid, 0);
    scan(8'h00, 8'h01, 8'h00, 8'h00);
    chk("t1_state_s2", key_state, 8'h00);
    tick();
    chk("t1_noevt_s2", evt_valid, 0);
    scan(8'h00, 8'h01, 8'h00, 8'h00);
    chk("t1_state_s3", key_state, 8'h02);
    chk("t1_valid_lat1", evt_valid, 0);
    tick();
    chk("t1_valid_lat2", evt_valid, 1);
    chk("t1_key", evt_key, 1);
    chk("t1_pressed", evt_pressed, 1);
    chk("t1_level", fifo_level, 1);
    tick();
    chk("t1_popped", evt_valid, 0);
    chk("t1_level0", fifo_level, 0);

    // Key 5 bounce 1,0,1,1,1: press only on the fifth scan.
    scan(8'h00, 8'h11, 8'h00, 8'h00);
    scan(8'h00, 8'h01, 8'h00, 8'h00);
    scan(8'h00, 8'h11, 8'h00, 8'h00);
    scan(8'h00, 8'h11, 8'h00, 8'h00);
    chk("t2_state_s4", key_state, 8'h02);
    tick();
    chk("t2_noevt_s4", evt_valid, 0);
    scan(8'h00, 8'h11, 8'h00, 8'h00);
    chk("t2_state_s5", key_state, 8'h22);
    tick();
    chk("t2_valid", evt_valid, 1);
    chk("t2_key", evt_key, 5);
    chk("t2_pressed", evt_pressed, 1);
    tick();
    chk("t2_popped", evt_valid, 0);

    // Keys 7, 0, 4 toggle on the same scan: queued in ascending order.
    evt_ready = 1'b0;
    scan3(8'h11, 8'h11, 8'h00, 8'h10);
    chk("t3_state", key_state, 8'hB3);
    tick();
    chk("t3_level1", fifo_level, 1);
    chk("t3_head0", evt_key, 0);
    tick();
    chk("t3_level2", fifo_level, 2);
    tick();
    chk("t3_level3", fifo_level, 3);
    chk("t3_head_hold", evt_key, 0);
    chk("t3_pressed0", evt_pressed, 1);
    evt_ready = 1'b1;
    tick();
    chk("t3_head4", evt_key, 4);
    chk("t3_level_d2", fifo_level, 2);
    tick();
    chk("t3_head7", evt_key, 7);
    chk("t3_pressed7", evt_pressed, 1);
    tick();
    chk("t3_empty", evt_valid, 0);

    // Ten events with the consumer stalled: FIFO holds 8, two stay pending.
    evt_ready = 1'b0;
    scan3(8'h00, 8'h00, 8'h00, 8'h00);
    idle(6);
    scan3(8'h11, 8'h01, 8'h01, 8'h01);
    idle(6);
    chk("t4_state", key_state, 8'h1F);
    chk("t4_level_full", fifo_level, 8);
    chk("t4_no_ovf", evt_overflow, 0);
    idle(3);
    chk("t4_level_hold", fifo_level, 8);
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_valid_%0d", i), evt_valid, 1);
      chk($sformatf("t4_evt_%0d", i), {evt_key, evt_pressed}, exp_d4[i]);
      tick();
    end
    chk("t4_drained", evt_valid, 0);
    chk("t4_level0", fifo_level, 0);

    // FIFO full, key 2 pending release, then re-pressed: overflow and new polarity.
    evt_ready = 1'b0;
    scan3(8'h00, 8'h00, 8'h01, 8'h00);
    idle(6);
    scan3(8'h11, 8'h01, 8'h01, 8'h01);
    idle(6);
    chk("t5_level_full", fifo_level, 8);
    scan3(8'h11, 8'h01, 8'h00, 8'h01);
    idle(3);
    chk("t5_state_rel", key_state, 8'h1B);
    chk("t5_no_ovf", evt_overflow, 0);
    scan3(8'h11, 8'h01, 8'h01, 8'h01);
    chk("t5_state_press", key_state, 8'h1F);
    chk("t5_ovf_set", evt_overflow, 1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("t5_ovf_clear", evt_overflow, 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t5_evt_%0d", i), {evt_valid, evt_key, evt_pressed}, {1'b1, exp_d5[i]});
      tick();
    end
    chk("t5_drained", evt_valid, 0);

    // Asynchronous reset with five events queued.
    evt_ready = 1'b0;
    scan3(8'h00, 8'h00, 8'h00, 8'h00);
    idle(6);
    chk("t6_level5", fifo_level, 5);
    evt_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_key", evt_key, 0);
    chk("t6_rst_pressed", evt_pressed, 0);
    chk("t6_rst_state", key_state, 8'h00);
    chk("t6_rst_ovf", evt_overflow, 0);
    tick();
    reset_n = 1'b1;
    idle(5);
    chk("t6_no_stale", evt_valid, 0);
    chk("t6_level_after", fifo_level, 0);
    scan3(8'h01, 8'h00, 8'h00, 8'h00);
    chk("t6_state_after", key_state, 8'h01);
    tick();
    chk("t6_evt_after", {evt_valid, evt_key, evt_pressed}, 5'b1_000_1);
    tick();
    chk("t6_final_empty", evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
